// File: rtl/mem_ctrl_sync.sv
// rtl/mem_ctrl_sync.sv - single-port synchronous word memory with request/response handshake and clear sequencer
//
// Ports:
//   clk        in   clock, all state updates on rising edge
//   reset      in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE only)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle completion strobe
//   rsp_rdata  out  read data, or written data for writes; held between responses
//   busy       out  state != IDLE
module mem_ctrl_sync #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int WAIT_STATES    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [3:0]              wait_cnt;
    logic [3:0]              wait_next;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic                    lat_write;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    commit;
    logic                    clr_we;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic                    c_write;
    logic [DATA_WIDTH-1:0]   c_wdata;

    assign req_ready = (state == ST_IDLE);
    assign busy      = !req_ready;

    always_comb begin
        next_state = state;
        wait_next  = wait_cnt;
        accept     = 1'b0;
        commit     = 1'b0;
        clr_we     = 1'b0;
        // Commit normally uses the latched request; with zero wait states
        // the commit happens on the accept edge, so the live inputs are used.
        c_addr     = lat_addr;
        c_write    = lat_write;
        c_wdata    = lat_wdata;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_ptr == {ADDR_WIDTH{1'b1}}) begin
                    next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        commit     = 1'b1;
                        c_addr     = req_addr;
                        c_write    = req_write;
                        c_wdata    = req_wdata;
                        next_state = ST_RESP;
                    end else begin
                        wait_next  = WAIT_LOAD;
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    commit     = 1'b1;
                    next_state = ST_RESP;
                end else begin
                    wait_next = wait_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RESET_STATE;
            clr_ptr   <= '0;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= next_state;
            wait_cnt  <= wait_next;
            rsp_valid <= commit;
            if (clr_we) begin
                clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
            end
            if (commit) begin
                rsp_rdata <= c_write ? c_wdata : mem[c_addr];
            end
        end
    end

    // Request latch carries no reset: it is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            lat_addr  <= req_addr;
            lat_write <= req_write;
            lat_wdata <= req_wdata;
        end
    end

    // Array writes are gated by reset so a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (clr_we) begin
                mem[clr_ptr] <= '0;
            end else if (commit && c_write) begin
                mem[c_addr] <= c_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl_sync.sv
// tb/tb_mem_ctrl_sync.sv - directed self-checking bench for mem_ctrl_sync
module tb_mem_ctrl_sync;

    logic        clk;
    logic        reset      [4];
    logic        req_valid  [4];
    logic        req_ready  [4];
    logic        req_write  [4];
    logic [3:0]  req_addr   [4];
    logic [15:0] req_wdata  [4];
    logic        rsp_valid  [4];
    logic [15:0] rsp_rdata  [4];
    logic        busy       [4];

    int checks;
    int failures;

    // Instance 0: WS=1 clear-on-reset, 1: WS=0 clear-on-reset,
    // 2: WS=3 retain-on-reset, 3: WS=3 clear-on-reset.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WS  = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        localparam int COR = (g == 2) ? 0 : 1;
        mem_ctrl_sync #(
            .DATA_WIDTH    (16),
            .ADDR_WIDTH    (4),
            .WAIT_STATES   (WS),
            .CLEAR_ON_RESET(COR)
        ) dut (
            .clk      (clk),
            .reset    (reset[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_write(req_write[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .busy     (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    task automatic do_txn(input int k, input bit wr, input logic [3:0] a,
                          input logic [15:0] d, input bit mess, output logic [15:0] rd);
        int n;
        n = 0;
        while (!req_ready[k] && n < 64) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = a;
        req_wdata[k] = d;
        tick();
        req_valid[k] = 1'b0;
        if (mess) begin
            req_addr[k]  = 4'd9;
            req_write[k] = 1'b1;
            req_wdata[k] = 16'hFFFF;
        end
        n = 0;
        while (!rsp_valid[k] && n < 32) begin
            tick();
            n++;
        end
        check("rsp_seen", 32'(rsp_valid[k]), 32'd1);
        check("latency", 32'(n), 32'(ws_of(k)));
        rd = rsp_rdata[k];
        tick();
        check("rsp_one_cycle", 32'(rsp_valid[k]), 32'd0);
        check("ready_after_rsp", 32'(req_ready[k]), 32'd1);
    endtask

    task automatic count_clear(input int k, output int n);
        n = 0;
        while (!req_ready[k] && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [15:0] rd;
        int n;
        int rises;
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 4; k++) begin
            reset[k]     = 1'b0;
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = 4'd0;
            req_wdata[k] = 16'd0;
        end

        // Test 1: reset held 2 cycles, then 16-cycle clear.
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_rdata", 32'(rsp_rdata[0]), 32'd0);
        check("rst_busy_clear", 32'(busy[0]), 32'd1);
        check("rst_ready_retain", 32'(req_ready[2]), 32'd1);
        for (int k = 0; k < 4; k++) reset[k] = 1'b1;
        count_clear(0, n);
        check("clear_cycles", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            do_txn(0, 1'b0, 4'(i), 16'd0, 1'b0, rd);
            check($sformatf("clear_rd%0d", i), 32'(rd), 32'h0000);
        end

        // Test 2: WS=1 write then read back.
        do_txn(0, 1'b1, 4'd3, 16'hBEEF, 1'b0, rd);
        check("wr3_rdata", 32'(rd), 32'hBEEF);
        do_txn(0, 1'b0, 4'd3, 16'h0000, 1'b0, rd);
        check("rd3", 32'(rd), 32'hBEEF);

        // Test 4: request inputs change during WAIT and are ignored.
        do_txn(0, 1'b0, 4'd3, 16'h0000, 1'b1, rd);
        check("wait_ignore_rd3", 32'(rd), 32'hBEEF);
        do_txn(0, 1'b0, 4'd9, 16'h0000, 1'b0, rd);
        check("wait_ignore_rd9", 32'(rd), 32'h0000);

        // Test 3: WS=0 with req_valid held high accepts every second edge.
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 4'd5;
        req_wdata[1] = 16'h1234;
        check("ws0_ready_pre", 32'(req_ready[1]), 32'd1);
        tick();
        check("ws0_wr_valid", 32'(rsp_valid[1]), 32'd1);
        check("ws0_wr_rdata", 32'(rsp_rdata[1]), 32'h1234);
        check("ws0_resp_ready", 32'(req_ready[1]), 32'd0);
        req_write[1] = 1'b0;
        req_wdata[1] = 16'h0000;
        tick();
        check("ws0_gap_valid", 32'(rsp_valid[1]), 32'd0);
        check("ws0_gap_ready", 32'(req_ready[1]), 32'd1);
        tick();
        check("ws0_rd_valid", 32'(rsp_valid[1]), 32'd1);
        check("ws0_rd_rdata", 32'(rsp_rdata[1]), 32'h1234);
        check("ws0_rd_ready", 32'(req_ready[1]), 32'd0);
        req_valid[1] = 1'b0;
        tick();
        check("ws0_end_valid", 32'(rsp_valid[1]), 32'd0);

        // Test 5a: retain-on-reset instance, reset during WAIT aborts write.
        do_txn(2, 1'b1, 4'd7, 16'h0000, 1'b0, rd);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 4'd7;
        req_wdata[2] = 16'hAAAA;
        tick();
        req_valid[2] = 1'b0;
        tick();
        reset[2] = 1'b0;
        rises = 0;
        tick();
        if (rsp_valid[2]) rises++;
        reset[2] = 1'b1;
        check("abort_ready_retain", 32'(req_ready[2]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid[2]) rises++;
        end
        check("abort_no_rsp_retain", 32'(rises), 32'd0);
        do_txn(2, 1'b0, 4'd7, 16'h0000, 1'b0, rd);
        check("abort_rd7_retain", 32'(rd), 32'h0000);

        // Test 5b: clear-on-reset instance, reset during WAIT reruns clear.
        do_txn(3, 1'b1, 4'd7, 16'h1111, 1'b0, rd);
        req_valid[3] = 1'b1;
        req_write[3] = 1'b1;
        req_addr[3]  = 4'd7;
        req_wdata[3] = 16'hAAAA;
        tick();
        req_valid[3] = 1'b0;
        tick();
        reset[3] = 1'b0;
        tick();
        reset[3] = 1'b1;
        check("abort_no_rsp_clear", 32'(rsp_valid[3]), 32'd0);
        count_clear(3, n);
        check("abort_clear_cycles", 32'(n), 32'd16);
        do_txn(3, 1'b0, 4'd7, 16'h0000, 1'b0, rd);
        check("abort_rd7_clear", 32'(rd), 32'h0000);

        // Test 6: address extremes do not alias.
        do_txn(0, 1'b1, 4'd15, 16'h5555, 1'b0, rd);
        do_txn(0, 1'b1, 4'd0, 16'h0001, 1'b0, rd);
        do_txn(0, 1'b0, 4'd15, 16'h0000, 1'b0, rd);
        check("rd15", 32'(rd), 32'h5555);
        do_txn(0, 1'b0, 4'd0, 16'h0000, 1'b0, rd);
        check("rd0", 32'(rd), 32'h0001);
        do_txn(0, 1'b0, 4'd3, 16'h0000, 1'b0, rd);
        check("rd3_final", 32'(rd), 32'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
